object_catcher: RTL

OBJECT_CATCHER -- requirements
Module: object_catcher

---
 rtl/object_catcher_pkg.sv | 20 ++
 rtl/object_catcher_catch_window.sv | 24 ++
 rtl/object_catcher.sv | 133 +++++++++++++
 3 files changed

// File: rtl/object_catcher_pkg.sv
// Shared game package: position width, the "no object" marker used by the
// object generator, and the catcher FSM state encoding.
package object_catcher_pkg;

  localparam int POS_W  = 11;  // horizontal position width
  localparam int Y_W    = 10;  // vertical position width
  localparam int DIFF_W = 12;  // unsigned |x - player| width

  // object_position value meaning "no object present" (UNDEFINED_POSITION)
  localparam logic [POS_W-1:0] UNDEF_POS = 11'd1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FALL  = 3'd1,
    JUDGE = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/object_catcher_catch_window.sv
// catch_window: combinational horizontal hit test, shared with the renderer.
// Ports:
//   a, b  : horizontal positions (POS_W bits, unsigned)
//   hit   : high when |a - b| <= HALF_WIDTH (12-bit unsigned difference)
module catch_window
  import object_catcher_pkg::*;
#(
  parameter int HALF_WIDTH = 32
) (
  input  logic [POS_W-1:0] a,
  input  logic [POS_W-1:0] b,
  output logic             hit
);

  logic signed [DIFF_W:0] diff;
  logic [DIFF_W-1:0]      abs_diff;

  always_comb begin
    diff     = $signed({2'b00, a}) - $signed({2'b00, b});
    abs_diff = diff[DIFF_W] ? DIFF_W'(-diff) : diff[DIFF_W-1:0];
    hit      = (abs_diff <= DIFF_W'(HALF_WIDTH));
  end

endmodule

// File: rtl/object_catcher.sv
// object_catcher: tracks one falling object from the generator, judges it
// against the player at the bottom row, and keeps score / lives.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   object_position   : generator x, UNDEFINED_POSITION when no object
//   player_position   : player x, sampled in the judge cycle
//   frame_tick        : one pulse per video frame, advances the fall
//   object_x/object_y : tracked object position
//   object_active     : object currently falling
//   catch_pulse       : one-cycle pulse after a catch
//   miss_pulse        : one-cycle pulse after a miss
//   score, lives      : caught count (saturating) and remaining lives
//   game_over         : set when lives reach 0, cleared only by rst
module object_catcher
  import object_catcher_pkg::*;
#(
  parameter int UNDEFINED_POSITION = int'(UNDEF_POS),
  parameter int FALL_STEP          = 4,
  parameter int BOTTOM_Y           = 440,
  parameter int CATCH_HALF_WIDTH   = 32,
  parameter int START_LIVES        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] object_position,
  input  logic [POS_W-1:0] player_position,
  input  logic             frame_tick,
  output logic [POS_W-1:0] object_x,
  output logic [Y_W-1:0]   object_y,
  output logic             object_active,
  output logic             catch_pulse,
  output logic             miss_pulse,
  output logic [15:0]      score,
  output logic [2:0]       lives,
  output logic             game_over
);

  localparam int               YE_W       = Y_W + 1;
  localparam logic [POS_W-1:0] NO_OBJ     = POS_W'(UNDEFINED_POSITION);
  localparam logic [Y_W:0]     STEP_EXT   = YE_W'(FALL_STEP);
  localparam logic [Y_W:0]     BOTTOM_EXT = YE_W'(BOTTOM_Y);
  localparam logic [Y_W-1:0]   BOTTOM_ROW = Y_W'(BOTTOM_Y);
  localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);

  state_t       state, state_nxt;
  logic         hit;
  logic         new_obj;
  logic         at_bottom;
  logic         last_life;
  logic [Y_W:0] y_sum;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign new_obj   = (object_position != NO_OBJ);
  // One extra bit so the overshoot test cannot wrap near the top of the range
  assign y_sum     = {1'b0, object_y} + STEP_EXT;
  assign at_bottom = (y_sum >= BOTTOM_EXT);
  assign last_life = (lives <= 3'd1);

  catch_window #(
    .HALF_WIDTH(CATCH_HALF_WIDTH)
  ) u_catch_window (
    .a  (object_x),
    .b  (player_position),
    .hit(hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (new_obj) state_nxt = FALL;
      FALL:    if (frame_tick && at_bottom) state_nxt = JUDGE;
      JUDGE:   state_nxt = (!hit && last_life) ? OVER : CLEAR;
      // Wait for the generator to drop this object so it is not judged twice
      CLEAR:   if (!new_obj) state_nxt = IDLE;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      object_x      <= NO_OBJ;
      object_y      <= '0;
      object_active <= 1'b0;
      catch_pulse   <= 1'b0;
      miss_pulse    <= 1'b0;
      score         <= '0;
      lives         <= LIVES_INIT;
      game_over     <= 1'b0;
    end else begin
      catch_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (new_obj) begin
            object_x      <= object_position;
            object_y      <= '0;
            object_active <= 1'b1;
          end
        end
        FALL: begin
          if (frame_tick) object_y <= at_bottom ? BOTTOM_ROW : y_sum[Y_W-1:0];
        end
        JUDGE: begin
          object_active <= 1'b0;
          if (hit) begin
            catch_pulse <= 1'b1;
            score       <= sat_inc16(score);
          end else begin
            miss_pulse <= 1'b1;
            if (lives != 3'd0) lives <= lives - 3'd1;
            if (last_life) game_over <= 1'b1;
          end
        end
        OVER: begin
          object_active <= 1'b0;
          game_over     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
